// File: rtl/share_recombiner.sv
// share_recombiner
//
// Collects a frame of SHARES Boolean (XOR) shares arriving one word at a time
// and emits the recombined value, the XOR of every share in the frame.
// A frame must be exactly SHARES shares long, with S_LAST on the final share
// only. A frame that ends early, or one that runs to SHARES shares without
// S_LAST, is dropped and reported by a one-cycle ERR pulse.
//
// Ports
//   C        input          clock, all state updates on the rising edge
//   R        input          synchronous active-high reset
//   S_VALID  input          share word present on S_DATA
//   S_DATA   input  WIDTH   one XOR share
//   S_LAST   input          marks the final share of a frame
//   S_READY  output         share accepted when S_VALID & S_READY
//   Q_VALID  output         recombined value present on Q_DATA
//   Q_DATA   output WIDTH   XOR of all shares of one frame
//   Q_READY  input          downstream takes Q_DATA when Q_VALID & Q_READY
//   ERR      output         one-cycle pulse on a frame-length violation

module share_recombiner #(
  parameter int WIDTH  = 8,
  parameter int SHARES = 3
) (
  input  logic             C,
  input  logic             R,
  input  logic             S_VALID,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_LAST,
  output logic             S_READY,
  output logic             Q_VALID,
  output logic [WIDTH-1:0] Q_DATA,
  input  logic             Q_READY,
  output logic             ERR
);

  // SHARES is 2..8, so the counter needs 1..3 bits.
  localparam int CNT_W = $clog2(SHARES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SHARES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] accu, accu_nxt;
  logic [WIDTH-1:0] q_data, q_data_nxt;
  logic             q_valid, q_valid_nxt;
  logic             err, err_nxt;
  logic             accept;

  // Ready is decoded from state only (plus reset, so nothing is taken while
  // the block is being cleared); it never looks at S_VALID or Q_READY.
  assign S_READY = !R && (state != HOLD);
  assign accept  = S_VALID && S_READY;

  assign Q_VALID = q_valid;
  assign Q_DATA  = q_data;
  assign ERR     = err;

  // Next-state and datapath decode. The share being accepted has index 0 in
  // IDLE and index cnt in ACC; both length violations reset the frame.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    accu_nxt    = accu;
    q_data_nxt  = q_data;
    q_valid_nxt = q_valid;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (S_LAST) begin
            // Index 0 can never be the last share since SHARES >= 2.
            err_nxt  = 1'b1;
            cnt_nxt  = '0;
            accu_nxt = '0;
          end else begin
            accu_nxt  = S_DATA;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACC;
          end
        end
      end

      ACC: begin
        if (accept) begin
          if ((cnt == LAST_IDX) && S_LAST) begin
            q_data_nxt  = accu ^ S_DATA;
            q_valid_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = HOLD;
          end else if ((cnt == LAST_IDX) || S_LAST) begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            accu_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            accu_nxt = accu ^ S_DATA;
            cnt_nxt  = cnt + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (q_valid && Q_READY) begin
          q_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every handshake and
  // silently discards any partial frame or pending result.
  always_ff @(posedge C) begin
    if (R) begin
      state   <= IDLE;
      cnt     <= '0;
      accu    <= '0;
      q_data  <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      accu    <= accu_nxt;
      q_data  <= q_data_nxt;
      q_valid <= q_valid_nxt;
      err     <= err_nxt;
    end
  end

endmodule
